inst_issue_queue: RTL and testbench

Parametrised instruction queue between fetch and decode/issue. Each cycle it accepts up to FETCH_W instruction/PC pairs and presents up to ISSUE_W head entries to the issue logic. The issue logic reports how many of those entries it consumed. The queue compacts sparse fetch groups and handles flush, stall and fill-level backpressure. It generalises the fixed two-in/two-out instruction buffer to arbitrary depth and widths.

---
 rtl/instq_pkg.sv | 17 +
 rtl/inst_issue_queue_if.sv | 56 +++++
 rtl/instq_compact.sv | 24 ++
 rtl/inst_issue_queue.sv | 148 ++++++++++++++
 tb/tb_inst_issue_queue.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/instq_pkg.sv
// Shared constants and width helpers for the instruction issue queue.
// Build option INSTQ_BYPASS_EN is consumed by inst_issue_queue.
package instq_pkg;

  typedef enum int {
    SINGLE_ISSUE = 1,
    DUAL_ISSUE   = 2
  } issue_mode_e;

  localparam int DEF_INST_W = 32;
  localparam int DEF_PC_W   = 32;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/inst_issue_queue_if.sv
// Fetch/issue-side bundle of the instruction issue queue.
// master = fetch+issue logic, slave = the queue itself.
interface inst_issue_queue_if
  import instq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = DUAL_ISSUE,
  parameter int INST_W  = DEF_INST_W,
  parameter int PC_W    = DEF_PC_W
);

  localparam int NW = $clog2(ISSUE_W + 1);
  localparam int CW = cnt_w(DEPTH);

  logic                       flush;
  logic                       stall;
  logic [FETCH_W-1:0]         in_valid;
  logic [FETCH_W*INST_W-1:0]  in_inst;
  logic [FETCH_W*PC_W-1:0]    in_pc;
  logic [NW-1:0]              issue_num;
  logic [ISSUE_W-1:0]         out_valid;
  logic [ISSUE_W*INST_W-1:0]  out_inst;
  logic [ISSUE_W*PC_W-1:0]    out_pc;
  logic [CW-1:0]              count;
  logic                       full;

  modport master (
    output flush,
    output stall,
    output in_valid,
    output in_inst,
    output in_pc,
    output issue_num,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  count,
    input  full
  );

  modport slave (
    input  flush,
    input  stall,
    input  in_valid,
    input  in_inst,
    input  in_pc,
    input  issue_num,
    output out_valid,
    output out_inst,
    output out_pc,
    output count,
    output full
  );

endinterface

// File: rtl/instq_compact.sv
// Prefix popcount of a fetch group: per-slot write offset
// and total number of valid slots.
module instq_compact #(
  parameter int FETCH_W = 2,
  parameter int OW      = $clog2(FETCH_W + 1)
) (
  input  logic [FETCH_W-1:0]         valid_i,
  output logic [FETCH_W-1:0][OW-1:0] off_o,
  output logic [OW-1:0]              total_o
);

  logic [OW-1:0] acc;

  always_comb begin
    acc   = '0;
    off_o = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      off_o[i] = acc;
      acc      = acc + OW'(valid_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/inst_issue_queue.sv
// Circular instruction queue between fetch and issue.
// Define INSTQ_BYPASS_EN to forward pushes into an empty queue.
module inst_issue_queue
  import instq_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = DUAL_ISSUE,
  parameter int INST_W  = DEF_INST_W,
  parameter int PC_W    = DEF_PC_W
) (
  input logic               clk,
  input logic               rst,
  inst_issue_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int OW = $clog2(FETCH_W + 1);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [INST_W-1:0] ram_inst_q [DEPTH];
  logic [PC_W-1:0]   ram_pc_q   [DEPTH];

  logic [FETCH_W-1:0][OW-1:0] off;
  logic [OW-1:0]              total;

  logic          full;
  logic          push_en;
  logic          pop_en;
  logic [CW-1:0] pushed;
  logic [CW-1:0] popped;

  logic [ISSUE_W-1:0]        ov;
  logic [ISSUE_W*INST_W-1:0] oi;
  logic [ISSUE_W*PC_W-1:0]   op;

  instq_compact #(
    .FETCH_W (FETCH_W),
    .OW      (OW)
  ) u_compact (
    .valid_i (q.in_valid),
    .off_o   (off),
    .total_o (total)
  );

  // Full leaves room for one whole fetch group.
  assign full    = (CW'(DEPTH) - count_q) < CW'(FETCH_W);
  assign push_en = !q.flush && !full;
  assign pop_en  = !q.flush && !q.stall;
  assign pushed  = push_en ? CW'(total) : '0;
  assign popped  = pop_en ? CW'(q.issue_num) : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(popped);
      tail_d  = tail_q + AW'(pushed);
      count_d = count_q + pushed - popped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Bypassed-and-consumed entries are still written; they sit
  // behind head and are never presented.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (q.in_valid[i]) begin
          ram_inst_q[tail_q + AW'(off[i])] <=
            q.in_inst[i*INST_W +: INST_W];
          ram_pc_q[tail_q + AW'(off[i])] <=
            q.in_pc[i*PC_W +: PC_W];
        end
      end
    end
  end

`ifdef INSTQ_BYPASS_EN
  logic byp;

  assign byp = !rst && push_en
            && (count_q == '0) && (total != '0);
`endif

  always_comb begin
    ov = '0;
    oi = '0;
    op = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (count_q > CW'(j)) begin
        ov[j] = 1'b1;
        oi[j*INST_W +: INST_W] =
          ram_inst_q[head_q + AW'(j)];
        op[j*PC_W +: PC_W] =
          ram_pc_q[head_q + AW'(j)];
      end
    end
`ifdef INSTQ_BYPASS_EN
    if (byp) begin
      for (int j = 0; j < ISSUE_W; j++) begin
        for (int k = 0; k < FETCH_W; k++) begin
          if (q.in_valid[k] && int'(off[k]) == j) begin
            ov[j] = 1'b1;
            oi[j*INST_W +: INST_W] =
              q.in_inst[k*INST_W +: INST_W];
            op[j*PC_W +: PC_W] =
              q.in_pc[k*PC_W +: PC_W];
          end
        end
      end
    end
`endif
  end

  assign q.out_valid = ov;
  assign q.out_inst  = oi;
  assign q.out_pc    = op;
  assign q.count     = count_q;
  assign q.full      = full;

  a_issue_le_avail : assert property (
    @(posedge clk) disable iff (rst)
    (!q.flush && !q.stall) |->
      (int'(q.issue_num) <= $countones(q.out_valid))
  );

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed table-driven bench for inst_issue_queue
// (DEPTH=16, FETCH_W=2, ISSUE_W=2, default build).
module tb_inst_issue_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  inst_issue_queue_if #(
    .DEPTH(16), .FETCH_W(2), .ISSUE_W(2),
    .INST_W(32), .PC_W(32)
  ) qi ();

  inst_issue_queue #(
    .DEPTH(16), .FETCH_W(2), .ISSUE_W(2),
    .INST_W(32), .PC_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (qi.slave)
  );

  typedef struct {
    logic        fl;
    logic        st;
    logic [1:0]  iv;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [1:0]  n;
    logic [4:0]  c;
    logic        f;
    logic [1:0]  v;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  localparam logic [31:0] IOFS = 32'h1000_0000;

  int npass = 0;
  int ntot  = 0;
  vec_t tv[$];

  function automatic vec_t mk(
    logic fl, logic st, logic [1:0] iv,
    logic [31:0] p0, logic [31:0] p1, logic [1:0] n,
    logic [4:0] c, logic f, logic [1:0] v,
    logic [31:0] e0, logic [31:0] e1);
    vec_t r;
    r.fl = fl; r.st = st; r.iv = iv;
    r.p0 = p0; r.p1 = p1; r.n = n;
    r.c = c; r.f = f; r.v = v;
    r.e0 = e0; r.e1 = e1;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic drive(logic fl, logic st, logic [1:0] iv,
                       logic [31:0] p0, logic [31:0] p1,
                       logic [1:0] n);
    qi.flush     = fl;
    qi.stall     = st;
    qi.in_valid  = iv;
    qi.in_pc     = {p1, p0};
    qi.in_inst   = {p1 + IOFS, p0 + IOFS};
    qi.issue_num = n;
  endtask

  task automatic check_out(string tag, logic [4:0] c,
                           logic f, logic [1:0] v,
                           logic [31:0] e0, logic [31:0] e1);
    chk({tag, ".count"}, 32'(qi.count), 32'(c));
    chk({tag, ".full"}, 32'(qi.full), 32'(f));
    chk({tag, ".valid"}, 32'(qi.out_valid), 32'(v));
    chk({tag, ".pc0"}, qi.out_pc[31:0], e0);
    chk({tag, ".pc1"}, qi.out_pc[63:32], e1);
    chk({tag, ".inst0"}, qi.out_inst[31:0],
        v[0] ? e0 + IOFS : 32'h0);
    chk({tag, ".inst1"}, qi.out_inst[63:32],
        v[1] ? e1 + IOFS : 32'h0);
  endtask

  initial begin
    drive(0, 0, 2'b00, 0, 0, 0);

    // basic push / pop / sparse group
    tv.push_back(mk(0,0,2'b11,32'h100,32'h104,0,
                    2,0,2'b11,32'h100,32'h104));
    tv.push_back(mk(0,0,2'b00,0,0,2, 0,0,2'b00,0,0));
    tv.push_back(mk(0,0,2'b10,32'h200,32'h208,0,
                    1,0,2'b01,32'h208,0));
    tv.push_back(mk(0,0,2'b00,0,0,1, 0,0,2'b00,0,0));
    // fill to 15, dropped push, drain 2
    for (int k = 0; k < 7; k++)
      tv.push_back(mk(0,0,2'b11,32'h400+8*k,32'h404+8*k,0,
                      5'(2*k+2),0,2'b11,32'h400,32'h404));
    tv.push_back(mk(0,0,2'b01,32'h480,0,0,
                    15,1,2'b11,32'h400,32'h404));
    tv.push_back(mk(0,0,2'b11,32'h500,32'h504,0,
                    15,1,2'b11,32'h400,32'h404));
    tv.push_back(mk(0,0,2'b00,0,0,2,
                    13,0,2'b11,32'h408,32'h40C));
    // flush beats push and pop
    tv.push_back(mk(1,0,2'b11,32'h700,32'h704,2,
                    0,0,2'b00,0,0));
    // walk head/tail to 15, then wrap
    tv.push_back(mk(0,0,2'b11,32'h800,32'h804,0,
                    2,0,2'b11,32'h800,32'h804));
    for (int j = 1; j < 7; j++)
      tv.push_back(mk(0,0,2'b11,32'h800+8*j,32'h804+8*j,2,
                      2,0,2'b11,32'h800+8*j,32'h804+8*j));
    tv.push_back(mk(0,0,2'b01,32'h900,0,2,
                    1,0,2'b01,32'h900,0));
    tv.push_back(mk(0,0,2'b00,0,0,1, 0,0,2'b00,0,0));
    tv.push_back(mk(0,0,2'b11,32'h300,32'h304,0,
                    2,0,2'b11,32'h300,32'h304));
    tv.push_back(mk(0,0,2'b00,0,0,1,
                    1,0,2'b01,32'h304,0));
    // stall blocks pop only
    tv.push_back(mk(0,0,2'b11,32'h600,32'h604,0,
                    3,0,2'b11,32'h304,32'h600));
    tv.push_back(mk(0,0,2'b01,32'h608,0,0,
                    4,0,2'b11,32'h304,32'h600));
    tv.push_back(mk(0,1,2'b00,0,0,2,
                    4,0,2'b11,32'h304,32'h600));
    tv.push_back(mk(0,1,2'b11,32'h610,32'h614,2,
                    6,0,2'b11,32'h304,32'h600));
    tv.push_back(mk(0,0,2'b00,0,0,2,
                    4,0,2'b11,32'h604,32'h608));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("reset", 0, 0, 2'b00, 0, 0);

    foreach (tv[r]) begin
      drive(tv[r].fl, tv[r].st, tv[r].iv,
            tv[r].p0, tv[r].p1, tv[r].n);
      @(posedge clk);
      #1;
      check_out($sformatf("v%0d", r), tv[r].c, tv[r].f,
                tv[r].v, tv[r].e0, tv[r].e1);
    end

    // reset mid-operation overrides a push
    rst = 1'b1;
    drive(0, 0, 2'b11, 32'hB00, 32'hB04, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_out("midrst", 0, 0, 2'b00, 0, 0);
    drive(0, 0, 2'b01, 32'hA00, 32'hA04, 0);
    @(posedge clk);
    #1;
    check_out("postrst", 1, 0, 2'b01, 32'hA00, 0);
    drive(0, 0, 2'b00, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
